// File: rtl/core_pkg.sv
// Shared result-bus types for the out-of-order core. Reservation stations,
// the ROB and the CDB broadcaster all use this definition of a completed result.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 5;
  localparam int N_IN   = 3;
  localparam int N_CH   = 2;

  localparam logic [TAG_W-1:0] TAG_FREE = '1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  dst_reg;
  } cdb_result_t;

  function automatic cdb_result_t idle_result();
    cdb_result_t r;
    r.tag     = TAG_FREE;
    r.data    = {DATA_W{1'b0}};
    r.dst_reg = {REG_W{1'b0}};
    return r;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Circular overflow buffer for completed results: up to three writes and two
// reads per cycle, oldest entries exposed at the head.
module cdb_result_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic                   clr,
  input  logic [1:0]             push_n,
  input  cdb_result_t [2:0]      push_data,
  input  logic [1:0]             pop_n,
  output cdb_result_t [1:0]      head_data,
  output logic [CNT_W-1:0]       count
);

  cdb_result_t       mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign count        = count_q;
  assign head_data[0] = mem_q[head_q];
  assign head_data[1] = mem_q[head_q + PTR_W'(1)];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (adv) begin
      if (clr) begin
        head_d  = {PTR_W{1'b0}};
        tail_d  = {PTR_W{1'b0}};
        count_d = {CNT_W{1'b0}};
      end else begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q - CNT_W'(pop_n) + CNT_W'(push_n);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: only slots behind the count are ever read.
  always_ff @(posedge clk) begin
    if (adv && !clr) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < push_n) begin
          mem_q[tail_q + PTR_W'(k)] <= push_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Result-broadcast driver: merges two ALU pipes and the LS pipe onto two
// registered CDB channels, spilling excess results to an in-order buffer.
module cdb_broadcaster
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic [N_IN-1:0]               in_en,
  input  logic [N_IN-1:0][TAG_W-1:0]    in_tag,
  input  logic [N_IN-1:0][DATA_W-1:0]   in_data,
  input  logic [N_IN-1:0][REG_W-1:0]    in_reg,
  output logic                          in_ready,
  output logic [N_CH-1:0]               cdb_en,
  output logic [N_CH-1:0][TAG_W-1:0]    cdb_tag,
  output logic [N_CH-1:0][DATA_W-1:0]   cdb_data,
  output logic [N_CH-1:0][REG_W-1:0]    cdb_reg,
  output logic                          ovf_err
);

  logic [CNT_W-1:0]  count_s;
  cdb_result_t [1:0] head_s;
  cdb_result_t [2:0] push_data_s;
  cdb_result_t       acc_list_s [3];
  logic [1:0]        push_n_s, npop_s, free_s, nacc_s;
  logic [N_IN-1:0]   acc_s;

  logic [N_CH-1:0]   ch_en_q, ch_en_d;
  cdb_result_t [1:0] ch_res_q, ch_res_d;
  logic              ovf_q, ovf_d;

  assign in_ready = rdy & (count_s != CNT_W'(DEPTH));
  assign acc_s    = in_en & {N_IN{in_ready & ~flush}};
  assign npop_s   = (count_s >= CNT_W'(2)) ? 2'd2 : count_s[1:0];
  assign free_s   = 2'd2 - npop_s;

  // Slot selection: buffered results first, then accepted inputs in index order.
  always_comb begin
    nacc_s = 2'd0;
    for (int i = 0; i < 3; i++) acc_list_s[i] = idle_result();
    for (int i = 0; i < N_IN; i++) begin
      if (acc_s[i]) begin
        acc_list_s[nacc_s] = '{tag: in_tag[i], data: in_data[i], dst_reg: in_reg[i]};
        nacc_s = nacc_s + 2'd1;
      end else begin
        nacc_s = nacc_s;
      end
    end

    ch_en_d     = 2'b00;
    ch_res_d[0] = idle_result();
    ch_res_d[1] = idle_result();
    case (npop_s)
      2'd2: begin
        ch_en_d  = 2'b11;
        ch_res_d = head_s;
      end
      2'd1: begin
        ch_en_d     = {(nacc_s != 2'd0), 1'b1};
        ch_res_d[0] = head_s[0];
        ch_res_d[1] = (nacc_s != 2'd0) ? acc_list_s[0] : idle_result();
      end
      2'd0: begin
        ch_en_d     = {(nacc_s >= 2'd2), (nacc_s != 2'd0)};
        ch_res_d[0] = (nacc_s != 2'd0) ? acc_list_s[0] : idle_result();
        ch_res_d[1] = (nacc_s >= 2'd2) ? acc_list_s[1] : idle_result();
      end
      default: begin
        ch_en_d = 2'b00;
      end
    endcase

    push_n_s    = 2'd0;
    push_data_s = {3{idle_result()}};
    case (free_s)
      2'd0: begin
        push_n_s       = nacc_s;
        push_data_s[0] = acc_list_s[0];
        push_data_s[1] = acc_list_s[1];
        push_data_s[2] = acc_list_s[2];
      end
      2'd1: begin
        push_n_s       = (nacc_s > 2'd1) ? nacc_s - 2'd1 : 2'd0;
        push_data_s[0] = acc_list_s[1];
        push_data_s[1] = acc_list_s[2];
      end
      2'd2: begin
        push_n_s       = (nacc_s > 2'd2) ? nacc_s - 2'd2 : 2'd0;
        push_data_s[0] = acc_list_s[2];
      end
      default: begin
        push_n_s = 2'd0;
      end
    endcase
  end

  assign ovf_d = ovf_q | (rdy & ~flush & ~in_ready & (|in_en));

  cdb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (rdy),
    .clr       (flush),
    .push_n    (push_n_s),
    .push_data (push_data_s),
    .pop_n     (npop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  // Broadcast channel registers; a flush idles both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_en_q  <= 2'b00;
      ch_res_q <= {2{idle_result()}};
      ovf_q    <= 1'b0;
    end else if (rdy) begin
      ovf_q <= ovf_d;
      if (flush) begin
        ch_en_q  <= 2'b00;
        ch_res_q <= {2{idle_result()}};
      end else begin
        ch_en_q  <= ch_en_d;
        ch_res_q <= ch_res_d;
      end
    end
  end

  assign ovf_err = ovf_q;
  assign cdb_en  = ch_en_q;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign cdb_tag[c]  = ch_res_q[c].tag;
    assign cdb_data[c] = ch_res_q[c].data;
    assign cdb_reg[c]  = ch_res_q[c].dst_reg;
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster: single/triple results,
// saturation ordering, overflow, flush, freeze and asynchronous reset.
module tb_cdb_broadcaster;
  import core_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n, rdy, flush;
  logic [N_IN-1:0]             in_en;
  logic [N_IN-1:0][TAG_W-1:0]  in_tag;
  logic [N_IN-1:0][DATA_W-1:0] in_data;
  logic [N_IN-1:0][REG_W-1:0]  in_reg;
  logic                        in_ready, ovf_err;
  logic [N_CH-1:0]             cdb_en;
  logic [N_CH-1:0][TAG_W-1:0]  cdb_tag;
  logic [N_CH-1:0][DATA_W-1:0] cdb_data;
  logic [N_CH-1:0][REG_W-1:0]  cdb_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdb_broadcaster #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_en(in_en), .in_tag(in_tag), .in_data(in_data), .in_reg(in_reg),
    .in_ready(in_ready), .cdb_en(cdb_en), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_reg(cdb_reg), .ovf_err(ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_en   = '0;
    in_tag  = '0;
    in_data = '0;
    in_reg  = '0;
  endtask

  // Result with tag t carries data A500_00tt and destination register t+1.
  task automatic put(input int i, input logic [3:0] t);
    in_en[i]   = 1'b1;
    in_tag[i]  = t;
    in_data[i] = 32'hA500_0000 | {28'h0, t};
    in_reg[i]  = {1'b0, t} + 5'd1;
  endtask

  task automatic put3(input logic [3:0] b);
    put(0, b);
    put(1, b + 4'd1);
    put(2, b + 4'd2);
  endtask

  task automatic exp_ch(input string n, input int c, input logic en, input logic [3:0] t);
    logic [31:0] d;
    logic [4:0]  r;
    d = en ? (32'hA500_0000 | {28'h0, t}) : 32'h0;
    r = en ? ({1'b0, t} + 5'd1) : 5'd0;
    check($sformatf("%s_ch%0d_en", n, c), 64'(cdb_en[c]), 64'(en));
    check($sformatf("%s_ch%0d_tag", n, c), 64'(cdb_tag[c]), en ? 64'(t) : 64'hF);
    check($sformatf("%s_ch%0d_data", n, c), 64'(cdb_data[c]), 64'(d));
    check($sformatf("%s_ch%0d_reg", n, c), 64'(cdb_reg[c]), 64'(r));
  endtask

  task automatic exp_idle(input string n);
    exp_ch(n, 0, 1'b0, 4'h0);
    exp_ch(n, 1, 1'b0, 4'h0);
  endtask

  task automatic fill4();
    for (int k = 1; k <= 4; k++) begin
      put3(4'(3 * k - 2));
      step();
      clr_in();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    clr_in();
    #12;
    exp_idle("reset");
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_ovf", 64'(ovf_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single result on ALU pipe 1.
    in_en[0] = 1'b1; in_tag[0] = 4'd3; in_data[0] = 32'h11; in_reg[0] = 5'd5;
    step();
    clr_in();
    check("single_en0", 64'(cdb_en[0]), 64'd1);
    check("single_tag0", 64'(cdb_tag[0]), 64'd3);
    check("single_data0", 64'(cdb_data[0]), 64'h11);
    check("single_reg0", 64'(cdb_reg[0]), 64'd5);
    exp_ch("single", 1, 1'b0, 4'h0);
    step();
    exp_idle("single_after");

    // Three results at once: third one is buffered for a cycle.
    put3(4'd1);
    step();
    clr_in();
    exp_ch("three_c1", 0, 1'b1, 4'd1);
    exp_ch("three_c1", 1, 1'b1, 4'd2);
    step();
    exp_ch("three_c2", 0, 1'b1, 4'd3);
    exp_ch("three_c2", 1, 1'b0, 4'h0);
    step();
    exp_idle("three_c3");

    // Saturation: 3/cycle for 4 cycles, then drain; order must be 1..12.
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) put3(4'(3 * k - 2));
      step();
      clr_in();
      exp_ch($sformatf("sat%0d", k), 0, 1'b1, 4'(2 * k - 1));
      exp_ch($sformatf("sat%0d", k), 1, 1'b1, 4'(2 * k));
      check($sformatf("sat%0d_in_ready", k), 64'(in_ready), (k == 4) ? 64'd0 : 64'd1);
    end
    step();
    exp_idle("sat_drained");

    // Overflow: a result presented while full is dropped and sets ovf_err.
    fill4();
    check("ovf_full_in_ready", 64'(in_ready), 64'd0);
    put(0, 4'd6);
    step();
    clr_in();
    check("ovf_set", 64'(ovf_err), 64'd1);
    exp_ch("ovf", 0, 1'b1, 4'd9);
    exp_ch("ovf", 1, 1'b1, 4'd10);
    check("ovf_in_ready", 64'(in_ready), 64'd1);
    put(0, 4'd13); put(1, 4'd14); put(2, 4'd5);
    step();
    clr_in();
    exp_ch("ovf_next", 0, 1'b1, 4'd11);
    exp_ch("ovf_next", 1, 1'b1, 4'd12);
    check("ovf_sticky", 64'(ovf_err), 64'd1);

    // Flush with three buffered entries plus incoming results.
    put3(4'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clr_in();
    exp_idle("flush");
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    exp_idle("flush_after");

    // Flush while completely full.
    fill4();
    check("full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("full_flush_in_ready", 64'(in_ready), 64'd1);
    exp_idle("full_flush");
    step();
    exp_idle("full_flush_after");

    // Freeze with two buffered entries; flush during freeze is ignored.
    put3(4'd1);
    step();
    clr_in();
    exp_ch("frz_pre1", 0, 1'b1, 4'd1);
    exp_ch("frz_pre1", 1, 1'b1, 4'd2);
    put3(4'd4);
    step();
    clr_in();
    exp_ch("frz_pre2", 0, 1'b1, 4'd3);
    exp_ch("frz_pre2", 1, 1'b1, 4'd4);
    rdy = 1'b0;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_ch($sformatf("frz%0d", k), 0, 1'b1, 4'd3);
      exp_ch($sformatf("frz%0d", k), 1, 1'b1, 4'd4);
      check($sformatf("frz%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    rdy = 1'b1;
    flush = 1'b0;
    step();
    exp_ch("frz_resume", 0, 1'b1, 4'd5);
    exp_ch("frz_resume", 1, 1'b1, 4'd6);
    step();
    exp_idle("frz_done");

    // Asynchronous reset mid-burst with three entries buffered.
    put3(4'd1);
    step();
    put3(4'd4);
    step();
    put3(4'd7);
    step();
    clr_in();
    #2;
    rst_n = 1'b0;
    #1;
    exp_idle("arst");
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_ovf", 64'(ovf_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_idle("arst_after");
    check("arst_after_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
